life_ctrl: RTL and testbench
============================

LIFE_CTRL -- requirements
Module: life_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV_W, default 24, width of generation-period divider.
REQ-002 SHALL have parameter GEN_W, default 16, width of generation counter.
REQ-003 SHALL have port clk  input  1  single clock for all state.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port cmd_valid  input  1  command offered.
REQ-006 SHALL have port cmd_op  input  2  command: 00 LOAD, 01 RUN, 10 PAUSE, 11 STEP.
REQ-007 SHALL have port cmd_ready  output  1  command accepted when cmd_valid&&cmd_ready.
REQ-008 SHALL have port tick_div  input  TICK_DIV_W  generation period minus 1, in clk cycles.
REQ-009 SHALL have port load_en  output  1  one-cycle pulse; grid copies cells_in.
REQ-010 SHALL have port step_en  output  1  request to grid to compute one generation.
REQ-011 SHALL have port step_ack  input  1  grid has completed the requested generation.
REQ-012 SHALL have port running  output  1  free-run mode active.
REQ-013 SHALL have port gen_count  output  GEN_W  generations completed since last LOAD.

Function
REQ-014 SHALL implement FSM states IDLE, LOAD, WAIT (divider counting), STEP (step_en high), all outputs registered.
REQ-015 SHALL drive cmd_ready=1 in IDLE and WAIT only; 0 in LOAD and STEP.
REQ-016 IDLE: LOAD->LOAD; RUN->set running, enter WAIT; STEP->STEP; PAUSE->no-op.
REQ-017 LOAD: load_en=1 for exactly one cycle (cycle after acceptance), gen_count<=0, running<=0, then IDLE.
REQ-018 WAIT: tick_div sampled on entry; counter 0..tick_div; on count==tick_div go STEP, so step_en rises tick_div+1 cycles after WAIT entry.
REQ-019 WAIT: PAUSE->clear running, clear divider, IDLE; LOAD->LOAD; RUN/STEP accepted as no-ops.
REQ-020 STEP: step_en held at 1 until step_ack sampled high; step_ack outside STEP ignored.
REQ-021 On step_ack in STEP: step_en<=0, gen_count<=gen_count+1 modulo 2^GEN_W (max wraps to 0); next WAIT if running else IDLE.
REQ-022 step_ack coincident with step_en rising edge (zero-latency grid) SHALL be honoured; minimum step period tick_div+2 cycles.

Reset
REQ-023 rst SHALL asynchronously force IDLE, load_en=0, step_en=0, running=0, gen_count=0, divider=0, cmd_ready=1 on first clock after release.
REQ-024 rst mid-STEP SHALL drop step_en immediately; no gen_count increment for the aborted step.

Configuration
REQ-025 With LIFE_CTRL_GENLIMIT_EN defined: ports gen_limit (input GEN_W) and done (output 1) SHALL exist.
REQ-026 With it: on step_ack, if gen_limit!=0 and incremented gen_count==gen_limit, running<=0, next IDLE, done pulses one cycle; gen_limit==0 means unlimited.
REQ-027 Without it: ports absent; RUN continues until PAUSE or LOAD.

Structure
REQ-028 Package life_pkg SHALL hold CELLS_X (32), CELLS_Y (CELLS_X/16*9), cmd_op encoding typedef and FSM state enum.
REQ-029 Divider SHALL be sub-module life_tick_div (load, enable, clear, terminal-count pulse).

Verification
REQ-030 LOAD accepted at cycle N -> load_en high only at N+1, gen_count=0, cmd_ready=1 at N+2.
REQ-031 tick_div=3, RUN, grid acks same cycle -> step_en high every 5 cycles, gen_count 1,2,3...
REQ-032 STEP in IDLE, step_ack delayed 7 cycles -> step_en high 7 cycles, gen_count+1, return IDLE, running=0.
REQ-033 PAUSE during WAIT -> no further step_en; RUN again -> step_en tick_div+1 cycles later.
REQ-034 gen_count=2^GEN_W-1, one step -> gen_count=0; with GENLIMIT_EN, gen_limit=4 from LOAD -> exactly 4 steps, done pulse, IDLE.
REQ-035 rst asserted during STEP -> step_en low asynchronously, gen_count=0, IDLE after release.

Source files
------------

// File: rtl/life_pkg.sv
// Shared types and constants for the Game-of-Life controller slice.
package life_pkg;

  localparam int CELLS_X = 32;
  localparam int CELLS_Y = CELLS_X / 16 * 9;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_RUN   = 2'b01,
    OP_PAUSE = 2'b10,
    OP_STEP  = 2'b11
  } cmd_op_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WAIT,
    ST_STEP
  } life_state_t;

endpackage

// File: rtl/life_tick_div.sv
// Generation-period divider: counts 0..period after a load, flags the terminal count.
module life_tick_div #(
  parameter int W = 24
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] period,
  output logic         tc
);

  logic [W-1:0] count_reg;
  logic [W-1:0] limit_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
      limit_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
      limit_reg <= '0;
    end else if (load) begin
      count_reg <= '0;
      limit_reg <= period;
    end else if (enable && (count_reg != limit_reg)) begin
      count_reg <= count_reg + W'(1);
    end
  end

  // Holds at the limit so the flag stays up until the controller leaves WAIT.
  assign tc = enable && (count_reg == limit_reg);

endmodule

// File: rtl/life_ctrl.sv
// Life grid sequencer: LOAD / RUN / PAUSE / STEP commands, paced generation requests.
// Optional LIFE_CTRL_GENLIMIT_EN adds gen_limit/done to stop after a set generation count.
module life_ctrl
  import life_pkg::*;
#(
  parameter int TICK_DIV_W = 24,
  parameter int GEN_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  input  logic [1:0]            cmd_op,
  output logic                  cmd_ready,
  input  logic [TICK_DIV_W-1:0] tick_div,
  output logic                  load_en,
  output logic                  step_en,
  input  logic                  step_ack,
  output logic                  running,
  output logic [GEN_W-1:0]      gen_count
`ifdef LIFE_CTRL_GENLIMIT_EN
  ,
  input  logic [GEN_W-1:0]      gen_limit,
  output logic                  done
`endif
);

  life_state_t      state_reg;
  logic             cmd_ready_reg;
  logic             load_en_reg;
  logic             step_en_reg;
  logic             running_reg;
  logic [GEN_W-1:0] gen_reg;

  cmd_op_t          op;
  logic             cmd_acc;
  logic [GEN_W-1:0] gen_next;
  logic             limit_hit;
  logic             div_load;
  logic             div_clear;
  logic             div_en;
  logic             div_tc;

  assign op       = cmd_op_t'(cmd_op);
  assign cmd_acc  = cmd_valid && cmd_ready_reg;
  assign gen_next = gen_reg + GEN_W'(1);

`ifdef LIFE_CTRL_GENLIMIT_EN
  logic done_reg;
  assign limit_hit = (gen_limit != '0) && (gen_next == gen_limit);
  assign done      = done_reg;
`else
  assign limit_hit = 1'b0;
`endif

  // Divider reloads on every WAIT entry so tick_div is sampled fresh each generation.
  always_comb begin
    div_en    = (state_reg == ST_WAIT);
    div_clear = div_en && cmd_acc && ((op == OP_PAUSE) || (op == OP_LOAD));
    div_load  = ((state_reg == ST_IDLE) && cmd_acc && (op == OP_RUN)) ||
                ((state_reg == ST_STEP) && step_ack && running_reg && !limit_hit);
  end

  life_tick_div #(
    .W(TICK_DIV_W)
  ) u_tick_div (
    .clk   (clk),
    .rst   (rst),
    .load  (div_load),
    .enable(div_en),
    .clear (div_clear),
    .period(tick_div),
    .tc    (div_tc)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      cmd_ready_reg <= 1'b1;
      load_en_reg   <= 1'b0;
      step_en_reg   <= 1'b0;
      running_reg   <= 1'b0;
      gen_reg       <= '0;
`ifdef LIFE_CTRL_GENLIMIT_EN
      done_reg      <= 1'b0;
`endif
    end else begin
      load_en_reg <= 1'b0;
`ifdef LIFE_CTRL_GENLIMIT_EN
      done_reg    <= 1'b0;
`endif
      case (state_reg)
        ST_IDLE: begin
          if (cmd_acc) begin
            case (op)
              OP_LOAD: begin
                state_reg     <= ST_LOAD;
                load_en_reg   <= 1'b1;
                cmd_ready_reg <= 1'b0;
                gen_reg       <= '0;
                running_reg   <= 1'b0;
              end
              OP_RUN: begin
                state_reg   <= ST_WAIT;
                running_reg <= 1'b1;
              end
              OP_STEP: begin
                state_reg     <= ST_STEP;
                step_en_reg   <= 1'b1;
                cmd_ready_reg <= 1'b0;
              end
              default: ;
            endcase
          end
        end
        ST_LOAD: begin
          state_reg     <= ST_IDLE;
          cmd_ready_reg <= 1'b1;
        end
        ST_WAIT: begin
          // A PAUSE or LOAD landing on the terminal count wins over the step.
          if (cmd_acc && (op == OP_PAUSE)) begin
            state_reg   <= ST_IDLE;
            running_reg <= 1'b0;
          end else if (cmd_acc && (op == OP_LOAD)) begin
            state_reg     <= ST_LOAD;
            load_en_reg   <= 1'b1;
            cmd_ready_reg <= 1'b0;
            gen_reg       <= '0;
            running_reg   <= 1'b0;
          end else if (div_tc) begin
            state_reg     <= ST_STEP;
            step_en_reg   <= 1'b1;
            cmd_ready_reg <= 1'b0;
          end
        end
        ST_STEP: begin
          if (step_ack) begin
            step_en_reg   <= 1'b0;
            cmd_ready_reg <= 1'b1;
            gen_reg       <= gen_next;
            if (running_reg && !limit_hit) begin
              state_reg <= ST_WAIT;
            end else begin
              state_reg   <= ST_IDLE;
              running_reg <= 1'b0;
            end
`ifdef LIFE_CTRL_GENLIMIT_EN
            done_reg <= limit_hit;
`endif
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign cmd_ready = cmd_ready_reg;
  assign load_en   = load_en_reg;
  assign step_en   = step_en_reg;
  assign running   = running_reg;
  assign gen_count = gen_reg;

endmodule

// File: tb/tb_life_ctrl.sv
// Bench for life_ctrl: directed scenarios plus random commands/acks against an event-time model.
`timescale 1ns/1ps
module tb_life_ctrl;
  import life_pkg::*;

  localparam int TW   = 8;
  localparam int GW   = 8;
  localparam int GMOD = 1 << GW;
`ifdef LIFE_CTRL_GENLIMIT_EN
  localparam bit GENLIM = 1'b1;
`else
  localparam bit GENLIM = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic [1:0]    cmd_op = 2'b00;
  logic          step_ack = 1'b0;
  logic [TW-1:0] tick_div = '0;
  logic [GW-1:0] gen_limit = '0;
  logic          cmd_ready, load_en, step_en, running, done;
  logic [GW-1:0] gen_count;

  life_ctrl #(.TICK_DIV_W(TW), .GEN_W(GW)) dut (
    .clk      (clk),
    .rst      (rst),
    .cmd_valid(cmd_valid),
    .cmd_op   (cmd_op),
    .cmd_ready(cmd_ready),
    .tick_div (tick_div),
    .load_en  (load_en),
    .step_en  (step_en),
    .step_ack (step_ack),
    .running  (running),
    .gen_count(gen_count)
`ifdef LIFE_CTRL_GENLIMIT_EN
    ,
    .gen_limit(gen_limit),
    .done     (done)
`endif
  );

`ifndef LIFE_CTRL_GENLIMIT_EN
  assign done = 1'b0;
`endif

  always #5 clk = ~clk;

  // Model: what the outputs should show in the current cycle, plus the absolute
  // edge number at which the next generation request is due while running.
  int cyc = 0;
  int n_cmp = 0;
  int n_bad = 0;
  bit m_loading, m_stepping, m_running, m_done;
  int m_gen;
  int m_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic string op_name(input logic [1:0] op);
    case (op)
      2'b00:   return "LOAD";
      2'b01:   return "RUN";
      2'b10:   return "PAUSE";
      default: return "STEP";
    endcase
  endfunction

  task automatic model_reset();
    m_loading = 0; m_stepping = 0; m_running = 0; m_done = 0;
    m_gen = 0; m_due = -1;
  endtask

  task automatic model_load();
    m_loading = 1; m_gen = 0; m_running = 0; m_due = -1;
  endtask

  task automatic model_edge(input bit v, input logic [1:0] op, input bit a);
    bit acc;
    acc = v && !m_loading && !m_stepping;
    cyc++;
    m_done = 0;
    if (m_loading) begin
      m_loading = 0;
    end else if (m_stepping) begin
      if (a) begin
        m_stepping = 0;
        m_gen = (m_gen + 1) % GMOD;
        if (GENLIM && gen_limit != 0 && m_gen == int'(gen_limit)) begin
          m_running = 0;
          m_done = 1;
        end
        if (m_running) m_due = cyc + int'(tick_div) + 1;
      end
    end else if (m_running) begin
      if (acc && op == OP_PAUSE) begin
        m_running = 0; m_due = -1;
      end else if (acc && op == OP_LOAD) begin
        model_load();
      end else if (cyc == m_due) begin
        m_stepping = 1;
      end
    end else if (acc) begin
      case (op)
        OP_LOAD: model_load();
        OP_RUN:  begin m_running = 1; m_due = cyc + int'(tick_div) + 1; end
        OP_STEP: m_stepping = 1;
        default: ;
      endcase
    end
  endtask

  task automatic compare_all();
    check("cmd_ready", cmd_ready, !m_loading && !m_stepping);
    check("load_en", load_en, m_loading);
    check("step_en", step_en, m_stepping);
    check("running", running, m_running);
    check("gen_count", gen_count, m_gen);
`ifdef LIFE_CTRL_GENLIMIT_EN
    check("done", done, m_done);
`endif
  endtask

  task automatic run_cycle(input bit v, input logic [1:0] op, input bit a);
    bit rdy;
    rdy = !m_loading && !m_stepping;
    cmd_valid = v; cmd_op = op; step_ack = a;
    @(posedge clk);
    if (v && rdy)
      $display("cycle %0d: %s accepted (gen=%0d tick_div=%0d)", cyc + 1, op_name(op), m_gen, tick_div);
    model_edge(v, op, a);
    @(negedge clk);
    cmd_valid = 0; step_ack = 0;
    compare_all();
  endtask

  task automatic stop_run();
    for (int i = 0; i < 20 && m_running; i++) run_cycle(1, OP_PAUSE, m_stepping);
  endtask

  initial begin
    int last_rise, n, hi_cnt, done_cnt, rises;
    bit prev_se, saw_wrap;
    logic [GW-1:0] prev_gen;

    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare_all();
    rst = 0;
    run_cycle(0, OP_LOAD, 0);

    // LOAD: load_en one cycle, ready again the cycle after
    run_cycle(1, OP_LOAD, 0);
    check("load_pulse", load_en, 1);
    run_cycle(0, OP_LOAD, 0);
    check("load_ready_back", cmd_ready, 1);

    // tick_div=3 free run with a zero-latency grid: one request every 5 cycles
    tick_div = 3;
    run_cycle(1, OP_RUN, 0);
    last_rise = -1; prev_se = 0;
    for (int i = 0; i < 22; i++) begin
      run_cycle(0, OP_LOAD, m_stepping);
      if (step_en && !prev_se) begin
        if (last_rise >= 0) check("step_period", cyc - last_rise, 5);
        last_rise = cyc;
      end
      prev_se = step_en;
    end

    // PAUSE in WAIT, quiet period, then RUN restarts the full divider period
    stop_run();
    for (int i = 0; i < 10; i++) run_cycle(0, OP_LOAD, 0);
    run_cycle(1, OP_RUN, 0);
    n = 0;
    while (!step_en && n < 20) begin
      run_cycle(0, OP_LOAD, 0);
      n++;
    end
    check("rerun_latency", n, 4);
    stop_run();

    // STEP from IDLE with the ack 7 cycles late
    run_cycle(1, OP_STEP, 0);
    hi_cnt = step_en ? 1 : 0;
    for (int i = 0; i < 6; i++) begin
      run_cycle(0, OP_LOAD, 0);
      if (step_en) hi_cnt++;
    end
    run_cycle(0, OP_LOAD, 1);
    if (step_en) hi_cnt++;
    check("step_hi_len", hi_cnt, 7);

    // Asynchronous reset in the middle of a step
    run_cycle(1, OP_STEP, 0);
    run_cycle(0, OP_LOAD, 0);
    #2 rst = 1;
    #1;
    $display("cycle %0d: reset asserted during step", cyc);
    check("rst_step_en", step_en, 0);
    check("rst_gen_count", gen_count, 0);
    model_reset();
    @(negedge clk);
    rst = 0;
    compare_all();

    // Generation counter wrap with the shortest period
    tick_div = 0;
    run_cycle(1, OP_LOAD, 0);
    run_cycle(0, OP_LOAD, 0);
    run_cycle(1, OP_RUN, 0);
    saw_wrap = 0; prev_gen = gen_count;
    for (int i = 0; i < 2 * GMOD + 8; i++) begin
      run_cycle(0, OP_LOAD, m_stepping);
      if (prev_gen == GW'(GMOD - 1) && gen_count == '0) saw_wrap = 1;
      prev_gen = gen_count;
    end
    check("gen_wrap_seen", saw_wrap, 1);
    stop_run();

`ifdef LIFE_CTRL_GENLIMIT_EN
    // Generation limit of 4: exactly four requests, one done pulse, back to idle
    gen_limit = 4; tick_div = 1;
    run_cycle(1, OP_LOAD, 0);
    run_cycle(0, OP_LOAD, 0);
    run_cycle(1, OP_RUN, 0);
    done_cnt = 0; rises = 0; prev_se = 0;
    for (int i = 0; i < 40; i++) begin
      run_cycle(0, OP_LOAD, m_stepping);
      if (done) done_cnt++;
      if (step_en && !prev_se) rises++;
      prev_se = step_en;
    end
    check("limit_done_pulses", done_cnt, 1);
    check("limit_steps", rises, 4);
    check("limit_gen", gen_count, 4);
    check("limit_running", running, 0);
`else
    done_cnt = 0; rises = 0;
`endif

    // Random commands, acks (including stray acks outside a step) and periods
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 63) == 0) tick_div = TW'($urandom_range(0, 4));
`ifdef LIFE_CTRL_GENLIMIT_EN
      if ($urandom_range(0, 127) == 0) gen_limit = GW'($urandom_range(0, 6));
`endif
      run_cycle($urandom_range(0, 9) == 0, 2'($urandom_range(0, 3)),
                m_stepping ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 7) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
